fp_issue_queue: RTL
===================

// Module: fp_issue_queue
// PURPOSE
//  Sits directly upstream of FPUnit. Buffers FP requests from the core pipeline in a FIFO.
//  Issues them one at a time to FPUnit with a one-cycle FP_Start pulse, then waits for FP_Done.
//  Delivers each result, with the request's destination tag, on a valid/ready writeback port.
// PARAMETERS
//  width  32  operand/result width (IEEE-754 single)
//  DEPTH  4   FIFO entries (power of 2, >=2)
//  TAG_W  4   destination-register tag width
// PORTS
//  CLK          in   1        clock, rising edge
//  RESET        in   1        asynchronous, active-high reset
//  req_valid    in   1        request present
//  req_ready    out  1        queue can accept (count < DEPTH)
//  req_op       in   1        0 = add, 1 = mul
//  req_opa      in   width    operand 1
//  req_opb      in   width    operand 2
//  req_tag      in   TAG_W    destination tag
//  FP_Start     out  1        one-cycle start pulse to FPUnit
//  FPUnitOp     out  1        op of head entry
//  FP_Operand1  out  width    head operand 1, stable from ISSUE until FP_Done
//  FP_Operand2  out  width    head operand 2, stable from ISSUE until FP_Done
//  FP_Busy      in   1        FPUnit busy
//  FP_Done      in   1        FPUnit result valid (one-cycle pulse)
//  FP_Result    in   width    FPUnit result
//  wb_valid     out  1        writeback valid (registered)
//  wb_ready     in   1        consumer accepts
//  wb_data      out  width    captured FP_Result
//  wb_tag       out  TAG_W    tag of the completed entry
//  q_count      out  clog2(DEPTH)+1  entries held, including the in-flight one
//  idle         out  1        state==IDLE && q_count==0
// BEHAVIOUR
//  Reset (async): FIFO pointers/count=0, state IDLE; FP_Start, wb_valid, wb_data, wb_tag = 0.
//   idle=1, req_ready=1. Any in-flight op is discarded; FPUnit shares RESET.
//  Enqueue on req_valid&&req_ready at the clock edge. req_ready depends only on the registered
//   count; a same-cycle pop does not free a slot until the next cycle.
//  Head entry remains in the FIFO until its result is captured. Push and pop in the same cycle
//   leave count unchanged.
//  FSM states:
//   IDLE:  count>0 && !FP_Busy -> ISSUE.
//   ISSUE: FP_Start=1 for exactly this cycle, with the head's op/operands driven -> WAIT.
//   WAIT:  FP_Start=0. On FP_Done: wb_data<=FP_Result, wb_tag<=head tag, wb_valid<=1,
//          pop head -> HOLD.
//   HOLD:  on wb_valid&&wb_ready: wb_valid<=0; go to ISSUE if remaining count>0 && !FP_Busy,
//          else IDLE.
//  FP_Done outside WAIT is ignored. FP_Operand1/2 and FPUnitOp are held (registered) from
//   entry to ISSUE until leaving WAIT.
//  Latency from empty queue: enqueue at edge 0; FP_Start high in cycle 1; wb_valid rises on
//   the edge after FP_Done is sampled.
//  Full: req_ready=0 while count==DEPTH; req_valid is ignored, with no overwrite or
//   corruption.
//  Backpressure: with wb_ready=0 the block stays in HOLD and issues nothing further.
//   wb_data/wb_tag stay stable.
//  Results are returned in request order; the FPUnit handles one operation at a time.
// TESTING
//  1 Single add 0x42400000+0x40A00000, tag 3, wb_ready=1 -> FP_Start one cycle after enqueue;
//    wb_data=0x42540000, wb_tag=3.
//  2 Back-to-back mul 0x42400000*0x40A00000 (tag1), then add 0x42C80000+0x43480000 (tag2)
//    -> wb in order: 0x43700000/1, then 0x43960000/2; exactly 2 FP_Start pulses.
//  3 Push DEPTH+1 requests with no pops -> req_ready=0 at count=4; 5th is not accepted;
//    all 4 complete correctly.
//  4 Hold wb_ready=0 for 20 cycles after the first result -> wb_valid stays 1, data stable,
//    no FP_Start; the queue drains after release.
//  5 Assert RESET while in WAIT -> all outputs 0 immediately, q_count=0, idle=1;
//    a later request completes normally.
//  6 Stray FP_Done pulse in IDLE -> no wb_valid, no count change.

Source files
------------

// File: rtl/fp_issue_queue.sv
// fp_issue_queue: FIFO of FP requests issued one at a time to FPUnit, results returned in order on a valid/ready port
module fp_issue_queue #(
  parameter int width = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_op,
  input  logic [width-1:0]           req_opa,
  input  logic [width-1:0]           req_opb,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       FP_Start,
  output logic                       FPUnitOp,
  output logic [width-1:0]           FP_Operand1,
  output logic [width-1:0]           FP_Operand2,
  input  logic                       FP_Busy,
  input  logic                       FP_Done,
  input  logic [width-1:0]           FP_Result,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [width-1:0]           wb_data,
  output logic [TAG_W-1:0]           wb_tag,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, HOLD = 2'd3;
  logic             mem_op  [DEPTH];
  logic [width-1:0] mem_opa [DEPTH];
  logic [width-1:0] mem_opb [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic             iss_op_q;
  logic [width-1:0] iss_opa_q, iss_opb_q;
  logic             wb_valid_q;
  logic [width-1:0] wb_data_q;
  logic [TAG_W-1:0] wb_tag_q;
  logic             push, pop, load, release_wb;
  always_comb begin
    push       = req_valid && req_ready;
    pop        = state_q == WAIT && FP_Done;
    release_wb = state_q == HOLD && wb_ready;
    // count_q already excludes the entry popped on FP_Done, so it is the remaining work in HOLD
    load       = (state_q == IDLE || release_wb) && count_q != '0 && !FP_Busy;
    count_d    = count_q + CW'(push) - CW'(pop);
    state_d    = load ? ISSUE : state_q == ISSUE ? WAIT : pop ? HOLD : release_wb ? IDLE : state_q;
  end
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_op[wr_ptr_q]  <= req_op;
      mem_opa[wr_ptr_q] <= req_opa;
      mem_opb[wr_ptr_q] <= req_opb;
      mem_tag[wr_ptr_q] <= req_tag;
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      iss_op_q   <= 1'b0;
      iss_opa_q  <= '0;
      iss_opb_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_tag_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) begin
        iss_op_q  <= mem_op[rd_ptr_q];
        iss_opa_q <= mem_opa[rd_ptr_q];
        iss_opb_q <= mem_opb[rd_ptr_q];
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        wb_valid_q <= 1'b1;
        wb_data_q  <= FP_Result;
        wb_tag_q   <= mem_tag[rd_ptr_q];
      end else if (release_wb) wb_valid_q <= 1'b0;
    end
  end
  assign req_ready   = count_q != CW'(DEPTH);
  assign FP_Start    = state_q == ISSUE;
  assign FPUnitOp    = iss_op_q;
  assign FP_Operand1 = iss_opa_q;
  assign FP_Operand2 = iss_opb_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_tag      = wb_tag_q;
  assign q_count     = count_q;
  assign idle        = state_q == IDLE && count_q == '0;
endmodule
